// File: rtl/pid_terms.sv
// pid_terms: front end of the PID loop. Each accepted ADC sample yields signed P, I and D
// error terms, then one pid_sum computation is launched over the sum_en/sum_rdy handshake.
// Terms stay frozen until pid_sum reports done, so its late-state sign reads remain valid.
// Optional feature: define PID_ANTIWINDUP_EN to clamp the integral to +/-INT_LIMIT.
module pid_terms #(
  parameter int unsigned ADC_WIDTH = 13,
  parameter int unsigned INT_LIMIT = 1 << 20
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            adc_valid,
  input  logic        [ADC_WIDTH-1:0]     adc_data,
  input  logic        [ADC_WIDTH-1:0]     setpoint,
  input  logic                            int_clr,
  input  logic                            sum_rdy,
  output logic                            sum_en,
  output logic signed [ADC_WIDTH-1:0]     proportional,
  output logic signed [ADC_WIDTH-1:0]     derivative,
  output logic signed [2*ADC_WIDTH-1:0]   integral,
  output logic                            busy,
  output logic                            sample_drop,
  output logic        [7:0]               drop_cnt
);

  localparam int unsigned W  = ADC_WIDTH;
  localparam int unsigned IW = 2 * ADC_WIDTH;

  // The clamp magnitude has to be representable as a positive 2W-bit signed value.
  if ((64'(INT_LIMIT) >> (IW - 1)) != 64'd0) begin : g_limit_check
    $error("INT_LIMIT must be below 2^(2*ADC_WIDTH-1)");
  end

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StLaunch,
    StWaitLo,
    StWaitHi
  } state_e;

  state_e                 state_q, state_d;
  logic        [W-1:0]    adc_q, adc_d;
  logic signed [W-1:0]    p_q, p_d;
  logic signed [W-1:0]    d_q, d_d;
  logic signed [W-1:0]    prev_q, prev_d;
  logic signed [IW-1:0]   i_q, i_d;
  logic                   first_q, first_d;
  logic                   clr_pend_q, clr_pend_d;
  logic                   drop_q, drop_d;
  logic        [7:0]      drop_cnt_q, drop_cnt_d;

  logic signed [W:0]      err_raw;
  logic signed [W-1:0]    err_sat;
  logic signed [W:0]      diff_raw;
  logic signed [W-1:0]    diff_sat;
  logic signed [IW:0]     isum_raw;
  logic signed [IW-1:0]   i_sat;
  logic signed [IW-1:0]   i_next;

  // Saturate a W+1-bit signed value into W bits; overflow shows as disagreeing top bits.
  function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] v);
    if (v[W] != v[W-1]) begin
      sat_w = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sat_w = v[W-1:0];
    end
  endfunction

  // Saturate an IW+1-bit signed value into IW bits.
  function automatic logic signed [IW-1:0] sat_iw(input logic signed [IW:0] v);
    if (v[IW] != v[IW-1]) begin
      sat_iw = v[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
    end else begin
      sat_iw = v[IW-1:0];
    end
  endfunction

  // Error, derivative and integral arithmetic used by the CALC state.
  always_comb begin
    err_raw  = $signed({1'b0, setpoint}) - $signed({1'b0, adc_q});
    err_sat  = sat_w(err_raw);
    diff_raw = $signed({err_sat[W-1], err_sat}) - $signed({prev_q[W-1], prev_q});
    diff_sat = sat_w(diff_raw);
    isum_raw = $signed({i_q[IW-1], i_q}) + $signed({{(IW + 1 - W){err_sat[W-1]}}, err_sat});
    i_sat    = sat_iw(isum_raw);
  end

`ifdef PID_ANTIWINDUP_EN
  localparam logic signed [IW-1:0] IntLim = IW'(INT_LIMIT);

  // Anti-windup: hold the accumulated error inside +/-INT_LIMIT.
  always_comb begin
    if (i_sat > IntLim) begin
      i_next = IntLim;
    end else if (i_sat < -IntLim) begin
      i_next = -IntLim;
    end else begin
      i_next = i_sat;
    end
  end
`else
  assign i_next = i_sat;
`endif

  // FSM next state and the single-cycle launch strobe.
  always_comb begin
    state_d = state_q;
    sum_en  = 1'b0;
    case (state_q)
      StIdle:   if (adc_valid) state_d = StCalc;
      StCalc:   state_d = StLaunch;
      StLaunch: begin
        if (sum_rdy) begin
          sum_en  = 1'b1;
          state_d = StWaitLo;
        end
      end
      // pid_sum drops sum_rdy one cycle after the launch; wait for that before waiting for done.
      StWaitLo: if (!sum_rdy) state_d = StWaitHi;
      StWaitHi: if (sum_rdy) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next state: clears only land in IDLE, terms only change in CALC.
  always_comb begin
    adc_d      = adc_q;
    p_d        = p_q;
    d_d        = d_q;
    i_d        = i_q;
    prev_d     = prev_q;
    first_d    = first_q;
    clr_pend_d = clr_pend_q | int_clr;
    case (state_q)
      StIdle: begin
        // A clear seen in this cycle is applied now, ahead of any sample arriving with it.
        if (clr_pend_q || int_clr) begin
          i_d        = '0;
          prev_d     = '0;
          first_d    = 1'b1;
          clr_pend_d = 1'b0;
        end
        if (adc_valid) adc_d = adc_data;
      end
      StCalc: begin
        p_d     = err_sat;
        d_d     = first_q ? '0 : diff_sat;
        i_d     = i_next;
        prev_d  = err_sat;
        first_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Dropped-sample pulse and saturating counter.
  always_comb begin
    drop_d     = adc_valid && (state_q != StIdle);
    drop_cnt_d = (drop_d && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  // State registers; reset also aborts any in-flight handshake.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      adc_q      <= '0;
      p_q        <= '0;
      d_q        <= '0;
      i_q        <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      clr_pend_q <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      adc_q      <= adc_d;
      p_q        <= p_d;
      d_q        <= d_d;
      i_q        <= i_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      clr_pend_q <= clr_pend_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign proportional = p_q;
  assign derivative   = d_q;
  assign integral     = i_q;
  assign busy         = (state_q != StIdle);
  assign sample_drop  = drop_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_pid_terms.sv
// Bench for pid_terms: a directed vector table, randomized samples checked against an
// arithmetic model, plus hand sequences for mid-handshake reset and drop counter saturation.
module tb_pid_terms;

  localparam int W   = 13;
  localparam int LIM = 10000;

`ifdef PID_ANTIWINDUP_EN
  localparam longint I3 = 10000;
  localparam longint I4 = 10000;
`else
  localparam longint I3 = 12285;
  localparam longint I4 = 16380;
`endif

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic                 adc_valid;
  logic [W-1:0]         adc_data;
  logic [W-1:0]         setpoint;
  logic                 int_clr;
  logic                 sum_rdy;
  logic                 sum_en;
  logic [W-1:0]         proportional;
  logic [W-1:0]         derivative;
  logic [2*W-1:0]       integral;
  logic                 busy;
  logic                 sample_drop;
  logic [7:0]           drop_cnt;

  pid_terms #(
    .ADC_WIDTH (W),
    .INT_LIMIT (LIM)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .setpoint     (setpoint),
    .int_clr      (int_clr),
    .sum_rdy      (sum_rdy),
    .sum_en       (sum_en),
    .proportional (proportional),
    .derivative   (derivative),
    .integral     (integral),
    .busy         (busy),
    .sample_drop  (sample_drop),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int sum_en_cnt = 0;

  always @(posedge clk) if (sum_en) sum_en_cnt <= sum_en_cnt + 1;

  // Reference model state
  longint m_int;
  int     m_prev;
  bit     m_first;
  bit     m_pend;
  int     m_drops;
  int     e_p, e_d;
  longint e_i;

  typedef struct {
    int     sp;
    int     adc;
    int     hold;
    int     lat;
    int     drops;
    bit     clr0;
    bit     clr_mid;
    int     p;
    int     d;
    longint i;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_terms(input string tag, input int p, input int d, input longint i);
    check({tag, "_p"}, longint'($signed(proportional)), p);
    check({tag, "_d"}, longint'($signed(derivative)), d);
    check({tag, "_i"}, longint'($signed(integral)), i);
  endtask

  function automatic longint clampv(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_clear();
    m_int   = 0;
    m_prev  = 0;
    m_first = 1;
    m_pend  = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_drops = 0;
  endtask

  task automatic model_step(input int sp, input int adc, input bit clr0);
    int es;
    if (m_pend || clr0) model_clear();
    es  = int'(clampv(sp - adc, -(1 << (W - 1)), (1 << (W - 1)) - 1));
    e_p = es;
    e_d = m_first ? 0 : int'(clampv(es - m_prev, -(1 << (W - 1)), (1 << (W - 1)) - 1));
    m_int = clampv(m_int + es, -(longint'(1) << (2 * W - 1)), (longint'(1) << (2 * W - 1)) - 1);
`ifdef PID_ANTIWINDUP_EN
    m_int = clampv(m_int, -LIM, LIM);
`endif
    e_i     = m_int;
    m_prev  = es;
    m_first = 0;
  endtask

  // Entered and left at a negedge of an IDLE cycle; that cycle becomes cycle 0.
  task automatic run_sample(input int sp, input int adc, input int hold, input int lat,
                            input int drops, input bit clr0, input bit clr_mid,
                            input int p, input int d, input longint i);
    int en0;
    en0       = sum_en_cnt;
    setpoint  = W'(sp);
    adc_data  = W'(adc);
    adc_valid = 1'b1;
    int_clr   = clr0;
    sum_rdy   = (hold == 0);
    @(posedge clk); #1;
    adc_valid = 1'b0;
    int_clr   = 1'b0;
    adc_data  = W'($urandom);
    @(negedge clk);
    check("busy_calc", busy, 1);
    check("sum_en_calc", sum_en, 0);
    @(posedge clk); #1;
    setpoint = W'($urandom);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("sum_en_hold", sum_en, 0);
      check_terms("hold", p, d, i);
      @(posedge clk); #1;
    end
    sum_rdy = 1'b1;
    @(negedge clk);
    check("sum_en_launch", sum_en, 1);
    check_terms("launch", p, d, i);
    @(posedge clk); #1;
    sum_rdy = 1'b0;
    @(negedge clk);
    check("sum_en_waitlo", sum_en, 0);
    for (int k = 0; k < lat; k++) begin
      @(posedge clk); #1;
      adc_valid = ((k % 2) == 0) && ((k / 2) < drops);
      int_clr   = clr_mid && (k == 0);
      if (adc_valid) m_drops++;
      @(negedge clk);
      check("drop_pulse", sample_drop, (k > 0) && (((k - 1) % 2) == 0) && (((k - 1) / 2) < drops));
    end
    if (clr_mid) m_pend = 1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    int_clr   = 1'b0;
    sum_rdy   = 1'b1;
    @(negedge clk);
    check("drop_pulse_last", sample_drop,
          (lat > 0) && (((lat - 1) % 2) == 0) && (((lat - 1) / 2) < drops));
    check("busy_return", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("sum_en_idle", sum_en, 0);
    check_terms("idle", p, d, i);
    check("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
    check("sum_en_count", sum_en_cnt - en0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2000, 1500, 0, 2, 0, 1'b0, 1'b0, 500, 0, 500};
    tbl[1] = '{2000, 1700, 1, 1, 0, 1'b0, 1'b0, 300, -200, 800};
    tbl[2] = '{8191, 0, 0, 1, 0, 1'b0, 1'b0, 4095, 3795, 4895};
    tbl[3] = '{0, 8191, 0, 4, 2, 1'b0, 1'b0, -4096, -4096, 799};
    tbl[4] = '{4095, 0, 0, 1, 0, 1'b1, 1'b0, 4095, 0, 4095};
    tbl[5] = '{4095, 0, 2, 0, 0, 1'b0, 1'b0, 4095, 0, 8190};
    tbl[6] = '{4095, 0, 0, 3, 1, 1'b0, 1'b0, 4095, 0, I3};
    tbl[7] = '{4095, 0, 0, 2, 0, 1'b0, 1'b1, 4095, 0, I4};

    n_rst     = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    setpoint  = '0;
    int_clr   = 1'b0;
    sum_rdy   = 1'b1;
    model_reset();
    #1;
    check("rst_sum_en", sum_en, 0);
    check("rst_busy", busy, 0);
    check_terms("rst", 0, 0, 0);
    check("rst_drop", sample_drop, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_sum_en", sum_en, 0);
    end

    // Directed table
    for (int v = 0; v < 8; v++) begin
      model_step(tbl[v].sp, tbl[v].adc, tbl[v].clr0);
      run_sample(tbl[v].sp, tbl[v].adc, tbl[v].hold, tbl[v].lat, tbl[v].drops,
                 tbl[v].clr0, tbl[v].clr_mid, tbl[v].p, tbl[v].d, tbl[v].i);
    end

    // The clear requested in WAIT_HI lands one IDLE cycle later.
    @(posedge clk); #1;
    @(negedge clk);
    check("clr_after_idle_i", longint'($signed(integral)), 0);
    model_clear();
    model_step(100, 0, 1'b0);
    run_sample(100, 0, 0, 1, 0, 1'b0, 1'b0, 100, 0, 100);

    // Randomized samples against the model
    for (int r = 0; r < 40; r++) begin
      int sp, adc, hold, lat, drops;
      bit clr0, clr_mid;
      sp      = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8191 : 0)
                                            : int'($urandom_range(0, 8191));
      adc     = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8191 : 0)
                                            : int'($urandom_range(0, 8191));
      hold    = $urandom_range(0, 2);
      lat     = $urandom_range(1, 4);
      drops   = $urandom_range(0, lat / 2);
      clr0    = ($urandom_range(0, 7) == 0);
      clr_mid = ($urandom_range(0, 7) == 0);
      model_step(sp, adc, clr0);
      run_sample(sp, adc, hold, lat, drops, clr0, clr_mid, e_p, e_d, e_i);
    end

    // Reset in the middle of a handshake
    setpoint  = W'(3000);
    adc_data  = '0;
    adc_valid = 1'b1;
    sum_rdy   = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sum_rdy = 1'b0;
    @(posedge clk); #1;
    adc_valid = 1'b1;
    int_clr   = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    int_clr   = 1'b0;
    check("pre_rst_busy", busy, 1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sum_en", sum_en, 0);
    check("mid_rst_drop", sample_drop, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    check_terms("mid_rst", 0, 0, 0);
    @(negedge clk);
    n_rst   = 1'b1;
    sum_rdy = 1'b1;
    model_reset();
    model_step(100, 300, 1'b0);
    run_sample(100, 300, 0, 1, 0, 1'b0, 1'b0, e_p, e_d, e_i);

    // Drop counter saturates at 255
    model_step(50, 60, 1'b0);
    run_sample(50, 60, 0, 520, 260, 1'b0, 1'b0, e_p, e_d, e_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
